// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the fetch PC, runs a single-outstanding
// req/gnt/rvalid imem port, and fills the IF/ID register with a one-entry skid buffer.
module if_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        Stall_IF,
  input  logic        Stall_ID,
  input  logic        Redirect_EX,
  input  logic [31:0] PCTarget_EX,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        valid_ID,
  output logic [31:0] instr_ID,
  output logic [31:0] pc_ID,
  output logic [31:0] pcplus4_ID
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] REQ  = 3'd1;
  localparam logic [2:0] WAIT = 3'd2;
  localparam logic [2:0] HOLD = 3'd3;
  localparam logic [2:0] KILL = 3'd4;

  logic [2:0]  state_q, state_d;
  logic [31:0] pc_f_q, pc_f_d;
  logic [31:0] buf_instr_q, buf_instr_d;
  logic        valid_id_q, valid_id_d;
  logic [31:0] instr_id_q, instr_id_d;
  logic [31:0] pc_id_q, pc_id_d;
  logic        deliver;
  logic        kill_pending;

  always_comb begin
    deliver      = !Stall_IF && !Stall_ID && !Redirect_EX;
    state_d      = state_q;
    pc_f_d       = pc_f_q;
    buf_instr_d  = buf_instr_q;
    valid_id_d   = valid_id_q;
    instr_id_d   = instr_id_q;
    pc_id_d      = pc_id_q;
    // An accepted request whose response has not yet returned must be drained.
    kill_pending = ((state_q == WAIT) && !imem_rvalid) ||
                   ((state_q == REQ)  &&  imem_gnt)    ||
                   ((state_q == KILL) && !imem_rvalid);

    if (!Stall_ID) begin
      valid_id_d = 1'b0;
      instr_id_d = NOP_INSTR;
    end

    case (state_q)
      IDLE: state_d = REQ;
      REQ: begin
        if (imem_gnt) state_d = WAIT;
      end
      WAIT: begin
        if (imem_rvalid) begin
          if (deliver) begin
            valid_id_d = 1'b1;
            instr_id_d = imem_rdata;
            pc_id_d    = pc_f_q;
            pc_f_d     = pc_f_q + 32'd4;
            state_d    = REQ;
          end else begin
            buf_instr_d = imem_rdata;
            state_d     = HOLD;
          end
        end
      end
      HOLD: begin
        if (deliver) begin
          valid_id_d = 1'b1;
          instr_id_d = buf_instr_q;
          pc_id_d    = pc_f_q;
          pc_f_d     = pc_f_q + 32'd4;
          state_d    = REQ;
        end
      end
      KILL: begin
        if (imem_rvalid) state_d = REQ;
      end
      default: state_d = IDLE;
    endcase

    if (Redirect_EX) begin
      pc_f_d     = PCTarget_EX & ~32'd3;
      valid_id_d = 1'b0;
      instr_id_d = NOP_INSTR;
      state_d    = kill_pending ? KILL : REQ;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      pc_f_q      <= RESET_PC;
      buf_instr_q <= NOP_INSTR;
      valid_id_q  <= 1'b0;
      instr_id_q  <= NOP_INSTR;
      pc_id_q     <= RESET_PC;
    end else begin
      state_q     <= state_d;
      pc_f_q      <= pc_f_d;
      buf_instr_q <= buf_instr_d;
      valid_id_q  <= valid_id_d;
      instr_id_q  <= instr_id_d;
      pc_id_q     <= pc_id_d;
    end
  end

  assign imem_req   = (state_q == REQ);
  assign imem_addr  = pc_f_q;
  assign valid_ID   = valid_id_q;
  assign instr_ID   = instr_id_q;
  assign pc_ID      = pc_id_q;
  assign pcplus4_ID = pc_id_q + 32'd4;

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: table of fetch transactions plus hand-written redirect
// sequences; deliveries are checked against a queue of expected {pc, instr}.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        Stall_IF = 1'b0, Stall_ID = 1'b0, Redirect_EX = 1'b0;
  logic [31:0] PCTarget_EX = 32'h0;
  logic        imem_req, imem_gnt = 1'b0, imem_rvalid = 1'b0;
  logic [31:0] imem_addr, imem_rdata = 32'h0;
  logic        valid_ID;
  logic [31:0] instr_ID, pc_ID, pcplus4_ID;

  logic        w_req, w_gnt, w_rvalid = 1'b0, w_valid;
  logic [31:0] w_addr, w_instr, w_pc, w_pcplus4;

  int n_cmp = 0;
  int n_err = 0;
  logic [63:0] q[$];

  always #5 clk = ~clk;

  if_stage dut (
    .clk(clk), .rst_n(rst_n), .Stall_IF(Stall_IF), .Stall_ID(Stall_ID),
    .Redirect_EX(Redirect_EX), .PCTarget_EX(PCTarget_EX),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .valid_ID(valid_ID), .instr_ID(instr_ID), .pc_ID(pc_ID), .pcplus4_ID(pcplus4_ID)
  );

  // Second instance starting at the top of the address space, on a zero-wait memory.
  if_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
    .clk(clk), .rst_n(rst_n), .Stall_IF(1'b0), .Stall_ID(1'b0),
    .Redirect_EX(1'b0), .PCTarget_EX(32'h0),
    .imem_req(w_req), .imem_addr(w_addr), .imem_gnt(w_gnt),
    .imem_rvalid(w_rvalid), .imem_rdata(32'h7777_7777),
    .valid_ID(w_valid), .instr_ID(w_instr), .pc_ID(w_pc), .pcplus4_ID(w_pcplus4)
  );

  assign w_gnt = w_req;
  always @(posedge clk) w_rvalid <= w_req && rst_n;

  typedef struct {
    logic        rst;
    int          glat;
    int          rlat;
    int          stall;
    logic [31:0] data;
    logic [31:0] addr;
  } vec_t;
  vec_t tbl[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Advance to the next falling edge and score any fresh IF/ID load.
  task automatic tick();
    logic        ls;
    logic [63:0] e;
    ls = Stall_ID;
    @(negedge clk);
    if (valid_ID && !ls && rst_n) begin
      if (q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_delivery: got pc=%h instr=%h want none", pc_ID, instr_ID);
      end else begin
        e = q.pop_front();
        check("deliver_pc", pc_ID, e[63:32]);
        check("deliver_instr", instr_ID, e[31:0]);
        check("deliver_pcplus4", pcplus4_ID, e[63:32] + 32'd4);
        $display("deliver pc=%h instr=%h", pc_ID, instr_ID);
      end
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; Stall_IF = 1'b0; Stall_ID = 1'b0; Redirect_EX = 1'b0;
    q.delete();
    tick();
    tick();
    check("rst_req", {31'b0, imem_req}, 32'd0);
    check("rst_addr", imem_addr, 32'h0);
    check("rst_valid", {31'b0, valid_ID}, 32'd0);
    check("rst_instr", instr_ID, 32'h13);
    check("rst_pc", pc_ID, 32'h0);
    rst_n = 1'b1;
    check("idle_req", {31'b0, imem_req}, 32'd0);
    tick();
    check("first_req", {31'b0, imem_req}, 32'd1);
    $display("reset done");
  endtask

  task automatic do_fetch(input int glat, input int rlat, input int stall,
                          input logic [31:0] data, input logic [31:0] addr);
    logic        ok;
    logic        v0;
    logic [31:0] i0, p0;
    int          n;
    n = 0;
    while (!imem_req && n < 50) begin tick(); n++; end
    check("req_seen", {31'b0, imem_req}, 32'd1);
    check("req_addr", imem_addr, addr);
    ok = 1'b1;
    repeat (glat) begin
      tick();
      if (!imem_req || imem_addr !== addr) ok = 1'b0;
    end
    if (glat > 0) check("addr_stable", {31'b0, ok}, 32'd1);
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0;
    repeat (rlat - 1) tick();
    imem_rvalid = 1'b1;
    imem_rdata  = data;
    q.push_back({addr, data});
    v0 = valid_ID; i0 = instr_ID; p0 = pc_ID;
    if (stall > 0) begin Stall_IF = 1'b1; Stall_ID = 1'b1; end
    tick();
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    if (stall > 0) begin
      for (int k = 1; k <= stall; k++) begin
        check("hold_state", {29'b0, dut.state_q}, 32'd3);
        check("hold_ifid", {valid_ID, instr_ID[30:0]} ^ pc_ID, {v0, i0[30:0]} ^ p0);
        if (k < stall) tick();
      end
      Stall_IF = 1'b0; Stall_ID = 1'b0;
      tick();
    end
    $display("fetch addr=%h data=%h glat=%0d rlat=%0d stall=%0d", addr, data, glat, rlat, stall);
  endtask

  initial begin
    tbl[0] = '{1'b1, 0, 1, 0, 32'h1111_1111, 32'h0};
    tbl[1] = '{1'b0, 0, 1, 0, 32'h2222_2222, 32'h4};
    tbl[2] = '{1'b0, 0, 1, 0, 32'h3333_3333, 32'h8};
    tbl[3] = '{1'b1, 0, 1, 0, 32'h0A0A_0A0A, 32'h0};
    tbl[4] = '{1'b0, 0, 1, 0, 32'h0B0B_0B0B, 32'h4};
    tbl[5] = '{1'b0, 0, 1, 3, 32'hAAAA_0000, 32'h8};
    tbl[6] = '{1'b0, 0, 1, 0, 32'hC0C0_C0C0, 32'hC};
    tbl[7] = '{1'b0, 3, 4, 0, 32'h9999_9999, 32'h100};
    tbl[8] = '{1'b0, 1, 2, 0, 32'h1234_5678, 32'h104};
    tbl[9] = '{1'b0, 0, 1, 2, 32'h8765_4321, 32'h108};

    for (int i = 0; i < 7; i++) begin
      if (tbl[i].rst) do_reset();
      do_fetch(tbl[i].glat, tbl[i].rlat, tbl[i].stall, tbl[i].data, tbl[i].addr);
    end

    // Redirect while the fetch of 0x10 is in flight; its response must be dropped.
    check("rw_addr", imem_addr, 32'h10);
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0;
    Redirect_EX = 1'b1; PCTarget_EX = 32'h200;
    tick();
    Redirect_EX = 1'b0;
    check("rw_valid", {31'b0, valid_ID}, 32'd0);
    check("rw_kill_req", {31'b0, imem_req}, 32'd0);
    imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    tick();
    imem_rvalid = 1'b0;
    check("rw_req", {31'b0, imem_req}, 32'd1);
    check("rw_target", imem_addr, 32'h200);
    $display("redirect-in-wait target=%h", imem_addr);

    // Redirect (misaligned target) while a stalled response sits in the skid buffer.
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0;
    imem_rvalid = 1'b1; imem_rdata = 32'h5555_5555;
    Stall_IF = 1'b1; Stall_ID = 1'b1;
    tick();
    imem_rvalid = 1'b0;
    check("rh_state", {29'b0, dut.state_q}, 32'd3);
    Redirect_EX = 1'b1; PCTarget_EX = 32'h103;
    tick();
    Redirect_EX = 1'b0; Stall_IF = 1'b0; Stall_ID = 1'b0;
    check("rh_req", {31'b0, imem_req}, 32'd1);
    check("rh_target", imem_addr, 32'h100);
    check("rh_valid", {31'b0, valid_ID}, 32'd0);
    $display("redirect-in-hold target=%h", imem_addr);

    for (int i = 7; i < 10; i++) begin
      if (tbl[i].rst) do_reset();
      do_fetch(tbl[i].glat, tbl[i].rlat, tbl[i].stall, tbl[i].data, tbl[i].addr);
    end
    check("next_addr", imem_addr, 32'h10C);
    check("queue_drained", q.size(), 32'd0);

    // Wrap-around on the second instance.
    do_reset();
    for (int n = 0; n < 20 && !w_valid; n++) tick();
    check("wrap_valid", {31'b0, w_valid}, 32'd1);
    check("wrap_pc", w_pc, 32'hFFFF_FFFC);
    check("wrap_pcplus4", w_pcplus4, 32'h0);
    check("wrap_instr", w_instr, 32'h7777_7777);
    check("wrap_next_addr", w_addr, 32'h0);
    $display("wrap pc=%h pcplus4=%h next=%h", w_pc, w_pcplus4, w_addr);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

endmodule
